uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
// - Receive end of the BLE command link: deserializes 8N1 UART frames on RX.
// - Frames are produced by UART_tx; typical commands are 'G' (8'h47) and 'S' (8'h53).
// - Presents each byte with a rdy/clr_rdy handshake to the command/auth logic in Segway.
// - Runs on the 50 MHz system clock.
// PARAMETERS
// - BAUD_DIV   2604   clocks per bit (50 MHz / 19200 baud); legal range >= 16
// - HALF_DIV   1302   clocks from detected start edge to start-bit mid-sample (BAUD_DIV/2)
// PORTS
// - clk        in   1  system clock; all logic on posedge
// - rst        in   1  synchronous, active-high reset
// - RX         in   1  asynchronous serial input; idles high
// - clr_rdy    in   1  consumer acknowledge; clears rdy
// - rx_data    out  8  last received byte, LSB first on the line; reset 8'h00
// - rdy        out  1  byte valid in rx_data; reset 0
// - frame_err  out  1  one-cycle pulse on a bad stop bit; reset 0
// BEHAVIOUR
// - RX passes through 2 flops, both reset to 1, before any use.
// - Start edge: synced RX == 0 while in IDLE.
// - FSM states: IDLE, START, DATA, STOP. Reset enters IDLE.
//   - IDLE -> START on start edge; baud counter loads HALF_DIV.
//   - START: at count expiry, sample synced RX.
//     - 0: go to DATA, reload BAUD_DIV, bit_cnt = 0.
//     - 1: false start (glitch); return to IDLE with no output change.
//   - DATA: at each expiry, shift the sample into shift_reg[7] (right shift), bit_cnt++.
//     After 8 samples go to STOP; reload BAUD_DIV on every expiry.
//   - STOP: at expiry, sample the stop bit, load rx_data <= shift_reg, set rdy, go to IDLE.
// - Counter rules:
//   - baud counter is 12-bit, counts down; expiry = count 0.
//   - bit_cnt is 4-bit, saturates; no wrap hazard.
// - Latency: rdy rises (9*BAUD_DIV + HALF_DIV) + 3 clk after the falling start edge
//   on the raw RX pin (2 sync stages + 1 registered set).
// - rx_data is stable while rdy == 1. It changes only at STOP completion.
// - rdy clears on clr_rdy, or on a new start edge detected in IDLE.
// - Simultaneous events: same-cycle set and clear (clr_rdy) -> set wins, so rdy stays 1.
// - Back-to-back frames: IDLE re-arms in the cycle after STOP; no idle gap is required.
// - Overrun: an unread byte is overwritten silently.
// - rst mid-frame: FSM to IDLE, counters to 0, rdy = 0, rx_data = 0, sync flops = 1;
//   the partial frame is discarded.
// - RX held low (break): one frame completes (bad stop), then the FSM waits in IDLE
//   until RX returns high before re-arming.
// CONFIGURATION
// - UART_CMD_RX_FRAME_ERR_EN defined:
//   - stop sample == 0: pulse frame_err for 1 clk, leave rx_data/rdy untouched.
// - Undefined:
//   - the stop bit is ignored; every frame sets rdy.
//   - frame_err is tied to 0.
// - The port list is identical in both builds.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t
//   - localparam BAUD_DIV_DEF = 2604
//   - localparam UART_DATA_W = 8
// - One sub-module, uart_baud_cnt: loadable down-counter.
//   - Ports: clk, rst, load, load_val[11:0], expire.
// - The synchronizer and FSM are inline.
// TESTING
// - Send 8'h47 via UART_tx -> rdy=1 within 9*2604+1302+3 clk; rx_data=8'h47.
// - rdy=1, pulse clr_rdy -> rdy=0 next clk; rx_data still 8'h47.
// - Frames 8'h47 then 8'h53 back-to-back, no clr_rdy -> rdy drops at the 2nd start edge;
//   rx_data=8'h53 at the end.
// - 200-clk low glitch on idle RX -> FSM returns to IDLE; rdy and rx_data unchanged.
// - rst asserted at bit 4 of 8'hA5, then a clean 8'h3C -> rx_data=8'h3C.
//   No residue from the aborted frame.
// - Frame with stop bit forced 0:
//   - _EN build: frame_err pulses 1 clk, rdy stays 0.
//   - Non-_EN build: rdy=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam int BAUD_DIV_DEF = 2604;
    localparam int UART_DATA_W  = 8;
    localparam int BAUD_CNT_W   = 12;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter. A load of N makes expire rise exactly N clocks
// later, so the FSM samples N clocks after the cycle that requested the load.
// Load values must be >= 1 (the receiver only uses values >= 8).
module uart_baud_cnt import uart_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BAUD_CNT_W-1:0] load_val,
    output logic                  expire
);

    logic [BAUD_CNT_W-1:0] cnt;

    // Count down to zero and park there; a load restarts the interval.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val - BAUD_CNT_W'(1);
        else if (cnt != '0)
            cnt <= cnt - BAUD_CNT_W'(1);
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command link, with rdy/clr_rdy byte handshake.
// Optional build macro UART_CMD_RX_FRAME_ERR_EN: a frame with a bad stop bit
// pulses frame_err and is dropped; without it the stop bit is ignored and
// frame_err is tied low.
module uart_cmd_rx import uart_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = BAUD_DIV_DEF / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX,
    input  logic                   clr_rdy,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rdy,
    output logic                   frame_err
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LD = BAUD_CNT_W'(BAUD_DIV);
    localparam logic [BAUD_CNT_W-1:0] HALF_LD = BAUD_CNT_W'(HALF_DIV);

    logic                   rx_meta, rx_s;
    uart_rx_state_t         state;
    logic [3:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   armed;
    logic                   start_edge;
    logic                   load;
    logic [BAUD_CNT_W-1:0]  load_val;
    logic                   expire;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // armed gates re-triggering after a break until the line has gone high again.
    assign start_edge = (state == IDLE) && !rx_s && armed;

    // Counter reload: half a bit to reach start-bit centre, then one bit per sample.
    always_comb begin
        load     = 1'b0;
        load_val = BAUD_LD;
        case (state)
            IDLE:  if (start_edge) begin
                       load     = 1'b1;
                       load_val = HALF_LD;
                   end
            START: load = expire && !rx_s;
            DATA:  load = expire;
            default: load = 1'b0;
        endcase
    end

    uart_baud_cnt u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // Receive FSM with registered outputs; a same-cycle set of rdy overrides clr_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            armed     <= 1'b1;
`ifdef UART_CMD_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
`ifdef UART_CMD_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (rx_s)
                armed <= 1'b1;
            if (clr_rdy)
                rdy <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state <= START;
                    rdy   <= 1'b0;
                end
                START: if (expire) begin
                    if (!rx_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end else begin
                        state <= IDLE;          // glitch, not a real start bit
                    end
                end
                DATA: if (expire) begin
                    shift_reg <= {rx_s, shift_reg[UART_DATA_W-1:1]};
                    if (bit_cnt != 4'hF)
                        bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7)
                        state <= STOP;
                end
                STOP: if (expire) begin
                    state <= IDLE;
                    if (!rx_s)
                        armed <= 1'b0;
`ifdef UART_CMD_RX_FRAME_ERR_EN
                    if (rx_s) begin
                        rx_data <= shift_reg;
                        rdy     <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
`else
                    rx_data <= shift_reg;
                    rdy     <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_CMD_RX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a short baud divider.
module tb_uart_cmd_rx;

    localparam int B = 32;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int lat;
    int fe0;

    uart_cmd_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // count clocks during which frame_err is high
    always @(posedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        wait_clks(B);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_clks(B);
        end
        RX = stop_bit;
        wait_clks(B);
        RX = 1'b1;
    endtask

    task automatic measure(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (rdy) break;
        end
    endtask

    task automatic clr_pulse();
        clr_rdy = 1'b1;
        wait_clks(1);
        clr_rdy = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        chk("rst_rdy", rdy, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", frame_err, 0);

        // first frame and exact latency from raw start edge
        fork
            send_byte(8'h47, 1'b1);
            measure(lat);
        join
        chk("latency", lat, 9*B + H + 3);
        chk("g_rdy", rdy, 1);
        chk("g_data", rx_data, 8'h47);

        clr_pulse();
        chk("clr_rdy", rdy, 0);
        chk("clr_data", rx_data, 8'h47);

        // clr_rdy coincident with the set edge: set wins
        fork
            send_byte(8'h47, 1'b1);
            begin
                wait_clks(9*B + H + 2);
                clr_rdy = 1'b1;
                wait_clks(1);
                clr_rdy = 1'b0;
            end
        join
        chk("set_wins", rdy, 1);

        // back-to-back 8'h53 with no gap and no clr_rdy
        fork
            send_byte(8'h53, 1'b1);
            begin
                wait_clks(2);
                chk("b2b_hold", rdy, 1);
                wait_clks(2);
                chk("b2b_drop", rdy, 0);
            end
        join
        chk("b2b_rdy", rdy, 1);
        chk("b2b_data", rx_data, 8'h53);

        // short low glitch shorter than half a bit
        clr_pulse();
        RX = 1'b0;
        wait_clks(6);
        RX = 1'b1;
        wait_clks(3*B);
        chk("glitch_rdy", rdy, 0);
        chk("glitch_data", rx_data, 8'h53);
        send_byte(8'hC3, 1'b1);
        chk("post_glitch", rx_data, 8'hC3);

        // reset in the middle of 8'hA5
        clr_pulse();
        RX = 1'b0;
        wait_clks(B);
        for (int i = 0; i < 4; i++) begin
            RX = a5[i];
            wait_clks(B);
        end
        RX = a5[4];
        wait_clks(B/2);
        rst = 1'b1;
        wait_clks(2);
        RX = 1'b1;
        rst = 1'b0;
        wait_clks(1);
        chk("midrst_rdy", rdy, 0);
        chk("midrst_data", rx_data, 0);
        wait_clks(B);
        send_byte(8'h3C, 1'b1);
        chk("after_rst_data", rx_data, 8'h3C);
        chk("after_rst_rdy", rdy, 1);

        // bad stop bit
        clr_pulse();
        fe0 = fe_cnt;
        send_byte(8'h5A, 1'b0);
        wait_clks(2);
`ifdef UART_CMD_RX_FRAME_ERR_EN
        chk("bad_stop_ferr", fe_cnt - fe0, 1);
        chk("bad_stop_rdy", rdy, 0);
        chk("bad_stop_data", rx_data, 8'h3C);
`else
        chk("bad_stop_ferr", fe_cnt - fe0, 0);
        chk("bad_stop_rdy", rdy, 1);
        chk("bad_stop_data", rx_data, 8'h5A);
`endif

        // break: one frame completes, then no re-arm while RX stays low
        clr_pulse();
        fe0 = fe_cnt;
        RX = 1'b0;
        wait_clks(12*B);
        clr_pulse();
        wait_clks(10*B);
        chk("brk_rdy", rdy, 0);
`ifdef UART_CMD_RX_FRAME_ERR_EN
        chk("brk_ferr", fe_cnt - fe0, 1);
        chk("brk_data", rx_data, 8'h3C);
`else
        chk("brk_ferr", fe_cnt - fe0, 0);
        chk("brk_data", rx_data, 8'h00);
`endif
        RX = 1'b1;
        wait_clks(B);
        send_byte(8'h47, 1'b1);
        chk("brk_recover", rx_data, 8'h47);
        chk("brk_recover_rdy", rdy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
